// File: rtl/imem_loader.sv
// Serial instruction-memory loader.
// Receives a little-endian 16-bit word count followed by that many
// little-endian 32-bit words over a byte stream, and writes each word
// to consecutive instruction-memory addresses starting at BASE_ADDR.
module imem_loader #(
  parameter int          MAX_WORDS = 64,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [31:0] MAX_WORDS_W = MAX_WORDS;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [15:0] words_q, words_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        error_q, error_d;

  logic        accept;
  logic [15:0] len_full;
  logic        len_too_big;

  // A byte is consumed only when offered and the loader is listening.
  assign accept      = byte_valid & byte_ready;
  // Full count as it will be once the high byte is taken this cycle.
  assign len_full    = {byte_in, len_q[7:0]};
  assign len_too_big = ({16'd0, len_full} > MAX_WORDS_W);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LEN;
      end
      LEN: begin
        if (accept && byte_cnt_q == 2'd1) begin
          if (len_full == 16'd0)  state_d = DONE;
          else if (len_too_big)   state_d = ERR;
          else                    state_d = DATA;
        end
      end
      DATA: begin
        if (accept && byte_cnt_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        if (words_q + 16'd1 == len_q) state_d = DONE;
        else                          state_d = DATA;
      end
      DONE: begin
        state_d = IDLE;
      end
      ERR: begin
        if (start) state_d = LEN;
      end
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    byte_ready = (state_q == LEN) || (state_q == DATA);
    mem_we     = (state_q == WRITE);
    busy       = (state_q == LEN) || (state_q == DATA) || (state_q == WRITE);
    done       = (state_q == DONE);
  end

  // Datapath next values: count capture, word assembly, write staging.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    word_d     = word_q;
    words_d    = words_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    error_d    = error_q;
    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          error_d    = 1'b0;
          words_d    = 16'd0;
          byte_cnt_d = 2'd0;
        end
      end
      LEN: begin
        if (accept) begin
          if (byte_cnt_q == 2'd0) begin
            len_d[7:0] = byte_in;
            byte_cnt_d = 2'd1;
          end else begin
            len_d[15:8] = byte_in;
            byte_cnt_d  = 2'd0;
            if (len_full != 16'd0 && len_too_big) error_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (accept) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = byte_in;
          // Counter wraps back to 0 after the fourth byte.
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Stage the write so address/data are stable for the whole
            // WRITE cycle and held afterwards.
            wdata_d = {byte_in, word_q[23:0]};
            addr_d  = BASE_ADDR + {46'd0, words_q, 2'b00};
          end
        end
      end
      WRITE: begin
        words_d = words_q + 16'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_q <= 2'd0;
      len_q      <= 16'd0;
      word_q     <= 32'd0;
      words_q    <= 16'd0;
      addr_q     <= 64'd0;
      wdata_q    <= 32'd0;
      error_q    <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      word_q     <= word_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      error_q    <= error_d;
    end
  end

  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: cycle-by-cycle vector table for the nominal
// load, then hand-written sequences for zero length, over-length,
// gapped bytes with stray start, mid-load reset and a non-zero base.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  byte_in;

  logic        r0, we0, busy0, done0, err0;
  logic [63:0] addr0;
  logic [31:0] wd0;
  logic [15:0] wl0;
  logic        r1, we1, busy1, done1, err1;
  logic [63:0] addr1;
  logic [31:0] wd1;
  logic [15:0] wl1;

  always #5 clk = ~clk;

  imem_loader #(.MAX_WORDS(64), .BASE_ADDR(64'd0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(r0), .mem_we(we0),
    .mem_addr(addr0), .mem_wdata(wd0), .busy(busy0), .done(done0),
    .error(err0), .words_loaded(wl0));

  imem_loader #(.MAX_WORDS(64), .BASE_ADDR(64'h1000)) dut1 (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(r1), .mem_we(we1),
    .mem_addr(addr1), .mem_wdata(wd1), .busy(busy1), .done(done1),
    .error(err1), .words_loaded(wl1));

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        st;
    logic        v;
    logic [7:0]  b;
    logic        rdy;
    logic        bsy;
    logic        we;
    logic        dn;
    logic        er;
    logic [15:0] wl;
    logic [63:0] ad;
    logic [31:0] wd;
  } vec_t;

  wr_t  wq0[$];
  wr_t  wq1[$];
  int   done_cnt0 = 0;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[19];
  logic [7:0]  nom_bytes[14];
  logic [63:0] nom_addr[3];
  logic [31:0] nom_data[3];

  // Write/done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (we0) begin
      wq0.push_back('{addr0, wd0});
      $display("write dut0 addr=%h data=%h", addr0, wd0);
    end
    if (we1) begin
      wq1.push_back('{addr1, wd1});
      $display("write dut1 addr=%h data=%h", addr1, wd1);
    end
    if (done0) done_cnt0++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte, waiting (bounded) for byte_ready first.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!r0 && n < 20) begin
      tick();
      n++;
    end
    if (!r0) begin
      checks++;
      errors++;
      $display("FAIL send_ready: got 0 expected 1 (byte %h)", b);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    $display("byte %h sent", b);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ready"}, r0, 0);
    chk({tag, ".busy"},  busy0, 0);
    chk({tag, ".we"},    we0, 0);
    chk({tag, ".done"},  done0, 0);
    chk({tag, ".error"}, err0, 0);
    chk({tag, ".wl"},    wl0, 0);
    chk({tag, ".addr"},  addr0, 0);
    chk({tag, ".wdata"}, wd0, 0);
    chk({tag, ".addr1"}, addr1, 0);
  endtask

  task automatic chk_nominal_writes(input string tag);
    chk({tag, ".nwr"}, wq0.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < wq0.size()) begin
        chk($sformatf("%s.wa%0d", tag, i), wq0[i].addr, nom_addr[i]);
        chk($sformatf("%s.wd%0d", tag, i), wq0[i].data, nom_data[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    nom_bytes = '{8'h03, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 8'h33,
                  8'h05, 8'hA5, 8'h00, 8'h33, 8'h85, 8'h05, 8'h40};
    nom_addr  = '{64'd0, 64'd4, 64'd8};
    nom_data  = '{32'h00000033, 32'h00A50533, 32'h40058533};
    //            st v  b      rdy bsy we dn er wl  addr  wdata
    tbl[0]  = '{1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 32'h0};
    tbl[1]  = '{0, 1, 8'h03, 1, 1, 0, 0, 0, 0, 0, 32'h0};
    tbl[2]  = '{0, 1, 8'h00, 1, 1, 0, 0, 0, 0, 0, 32'h0};
    tbl[3]  = '{0, 1, 8'h33, 1, 1, 0, 0, 0, 0, 0, 32'h0};
    tbl[4]  = '{0, 1, 8'h00, 1, 1, 0, 0, 0, 0, 0, 32'h0};
    tbl[5]  = '{0, 1, 8'h00, 1, 1, 0, 0, 0, 0, 0, 32'h0};
    tbl[6]  = '{0, 1, 8'h00, 0, 1, 1, 0, 0, 0, 0, 32'h00000033};
    tbl[7]  = '{0, 1, 8'hFF, 1, 1, 0, 0, 0, 1, 0, 32'h00000033};
    tbl[8]  = '{0, 1, 8'h33, 1, 1, 0, 0, 0, 1, 0, 32'h00000033};
    tbl[9]  = '{0, 1, 8'h05, 1, 1, 0, 0, 0, 1, 0, 32'h00000033};
    tbl[10] = '{0, 1, 8'hA5, 1, 1, 0, 0, 0, 1, 0, 32'h00000033};
    tbl[11] = '{0, 1, 8'h00, 0, 1, 1, 0, 0, 1, 4, 32'h00A50533};
    tbl[12] = '{0, 0, 8'h00, 1, 1, 0, 0, 0, 2, 4, 32'h00A50533};
    tbl[13] = '{0, 1, 8'h33, 1, 1, 0, 0, 0, 2, 4, 32'h00A50533};
    tbl[14] = '{0, 1, 8'h85, 1, 1, 0, 0, 0, 2, 4, 32'h00A50533};
    tbl[15] = '{0, 1, 8'h05, 1, 1, 0, 0, 0, 2, 4, 32'h00A50533};
    tbl[16] = '{0, 1, 8'h40, 0, 1, 1, 0, 0, 2, 8, 32'h40058533};
    tbl[17] = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 3, 8, 32'h40058533};
    tbl[18] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 3, 8, 32'h40058533};

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    tick();
    tick();
    chk_reset_outputs("rst");
    reset = 1'b0;

    // Nominal load, checked every cycle.
    for (int i = 0; i < 19; i++) begin
      start      = tbl[i].st;
      byte_valid = tbl[i].v;
      byte_in    = tbl[i].b;
      tick();
      chk($sformatf("v%0d.ready", i), r0, tbl[i].rdy);
      chk($sformatf("v%0d.busy", i),  busy0, tbl[i].bsy);
      chk($sformatf("v%0d.we", i),    we0, tbl[i].we);
      chk($sformatf("v%0d.done", i),  done0, tbl[i].dn);
      chk($sformatf("v%0d.error", i), err0, tbl[i].er);
      chk($sformatf("v%0d.wl", i),    wl0, tbl[i].wl);
      chk($sformatf("v%0d.addr", i),  addr0, tbl[i].ad);
      chk($sformatf("v%0d.wdata", i), wd0, tbl[i].wd);
    end
    start = 1'b0; byte_valid = 1'b0;
    chk_nominal_writes("tbl");

    // Zero-length load.
    wq0.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    chk("zero.done", done0, 1);
    chk("zero.busy", busy0, 0);
    chk("zero.wl", wl0, 0);
    tick();
    chk("zero.done_end", done0, 0);
    chk("zero.nwr", wq0.size(), 0);

    // Over-length count (65 > 64).
    pulse_start();
    send_byte(8'h41);
    send_byte(8'h00);
    chk("over.error", err0, 1);
    chk("over.ready", r0, 0);
    chk("over.busy", busy0, 0);
    byte_in = 8'h12; byte_valid = 1'b1;
    tick(); tick(); tick();
    byte_valid = 1'b0;
    chk("over.error_hold", err0, 1);
    chk("over.nwr", wq0.size(), 0);
    pulse_start();
    chk("over.clear", err0, 0);
    chk("over.relen_busy", busy0, 1);
    chk("over.relen_ready", r0, 1);
    send_byte(8'h00);
    send_byte(8'h00);
    tick();

    // Gapped bytes with start pulsed mid-load.
    wq0.delete();
    done_cnt0 = 0;
    pulse_start();
    for (int i = 0; i < 14; i++) begin
      send_byte(nom_bytes[i]);
      start = (i == 5 || i == 8 || i == 11 || i == 13);
      tick();
      start = 1'b0;
    end
    tick();
    tick();
    chk("gap.wl", wl0, 3);
    chk("gap.done_cnt", done_cnt0, 1);
    chk("gap.busy", busy0, 0);
    chk_nominal_writes("gap");

    // Reset after the sixth byte, with start and a byte in the same cycle.
    wq0.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(nom_bytes[i]);
    chk("mid.we", we0, 1);
    chk("mid.addr", addr0, 0);
    chk("mid.wdata", wd0, 32'h33);
    reset = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_in = 8'h77;
    tick();
    chk_reset_outputs("midrst");
    reset = 1'b0; start = 1'b0; byte_valid = 1'b0;
    tick();
    chk("midrst.idle", busy0, 0);
    chk("midrst.nwr", wq0.size(), 1);
    wq0.delete();
    pulse_start();
    for (int i = 0; i < 14; i++) send_byte(nom_bytes[i]);
    tick();
    chk("fresh.wl", wl0, 3);
    chk_nominal_writes("fresh");
    tick();

    // Two-word load observed on both base addresses.
    wq0.delete();
    wq1.delete();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    tick();
    tick();
    chk("base.nwr0", wq0.size(), 2);
    chk("base.nwr1", wq1.size(), 2);
    if (wq0.size() == 2 && wq1.size() == 2) begin
      chk("base.a00", wq0[0].addr, 64'h0);
      chk("base.a01", wq0[1].addr, 64'h4);
      chk("base.a10", wq1[0].addr, 64'h1000);
      chk("base.a11", wq1[1].addr, 64'h1004);
      chk("base.d10", wq1[0].data, 32'h44332211);
      chk("base.d11", wq1[1].data, 32'h88776655);
    end
    chk("base.wl1", wl1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter MAX_WORDS, default 64, meaning instruction-memory depth in 32-bit words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 64'd0, meaning the byte address of the first written word.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  one-cycle request to begin a load.
REQ-007 Port: byte_in  input  8  serial load byte.
REQ-008 Port: byte_valid  input  1  byte_in is valid.
REQ-009 Port: byte_ready  output  1  loader can accept a byte.
REQ-010 Port: mem_we  output  1  instruction-memory write enable.
REQ-011 Port: mem_addr  output  64  instruction-memory byte address.
REQ-012 Port: mem_wdata  output  32  instruction word to write.
REQ-013 Port: busy  output  1  load in progress.
REQ-014 Port: done  output  1  one-cycle load-complete pulse.
REQ-015 Port: error  output  1  sticky length-error flag.
REQ-016 Port: words_loaded  output  16  count of words written in the current or last load.

Function
REQ-017 The state machine SHALL have exactly these states: IDLE, LEN, DATA, WRITE, DONE, ERR.
REQ-018 A byte SHALL be accepted only on a clock edge where byte_valid=1 and byte_ready=1.
REQ-019 byte_ready SHALL be 1 only in LEN and DATA.
REQ-020 In IDLE, start=1 SHALL cause: transition to LEN, error cleared, words_loaded cleared, byte counter cleared.
REQ-021 start SHALL be ignored in every state other than IDLE and ERR.
REQ-022 In LEN, two accepted bytes SHALL form word count N, little-endian (first byte = N[7:0]).
REQ-023 After the second LEN byte: N=0 -> DONE; N>MAX_WORDS -> ERR; otherwise -> DATA.
REQ-024 In DATA, four accepted bytes SHALL form one word, little-endian (first byte = bits 7:0).
REQ-025 The fourth DATA byte SHALL cause transition to WRITE.
REQ-026 WRITE SHALL last exactly one cycle, with mem_we=1, mem_wdata = assembled word, and mem_addr = BASE_ADDR + 4*words_loaded.
REQ-027 Latency: last byte of a word accepted at edge k -> mem_we high during the cycle following edge k.
REQ-028 On leaving WRITE, words_loaded SHALL increment by 1, then: words_loaded = N -> DONE; otherwise -> DATA.
REQ-029 mem_we SHALL be 0 in every state except WRITE.
REQ-030 mem_addr and mem_wdata SHALL hold their last values outside WRITE.
REQ-031 DONE SHALL last one cycle, with done=1, then return to IDLE.
REQ-032 ERR SHALL hold error=1 and byte_ready=0.
REQ-033 In ERR, start=1 SHALL clear error and go to LEN.
REQ-034 busy SHALL be 1 in LEN, DATA and WRITE, and 0 otherwise.
REQ-035 Address arithmetic SHALL be 64-bit unsigned with wrap-around; no overflow detection.
REQ-036 The loader SHALL NOT clear memory words it does not write.

Reset
REQ-037 reset=1 at a clock edge SHALL force: state IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, words_loaded=0, assembly registers=0.
REQ-038 reset SHALL take priority over start and byte acceptance in the same cycle.
REQ-039 Reset mid-load SHALL abort the load with no further writes; words already written stay in memory.

Verification
REQ-040 Nominal load: start, then bytes 03 00 33 00 00 00 33 05 A5 00 33 85 05 40 -> three writes at addresses 0/4/8 with data 00000033/00A50533/40058533, done pulse, words_loaded=3.
REQ-041 Zero-length load: start, then bytes 00 00 -> no mem_we, done pulses on the cycle after the second byte, words_loaded=0.
REQ-042 Over-length load with MAX_WORDS=64: count bytes 41 00 -> ERR, error=1, byte_ready=0, no write; a following start clears error.
REQ-043 Valid gaps and start while busy: byte_valid toggling every other cycle, plus start asserted mid-load -> same writes as REQ-040, and start has no effect.
REQ-044 Reset after the 6th byte of REQ-040 stream -> one write already done (addr 0), all outputs at reset values, then a fresh load completes correctly.
REQ-045 BASE_ADDR=64'h1000 with a 2-word load -> writes at 0x1000 and 0x1004.
